// File: rtl/bus_register_bank.sv
// Parametrised register bank: one-hot write port, registered one-hot read
// port with bypass, sticky select-error flag and a sequential dump engine.
module bus_register_bank #(
    parameter int WIDTH   = 32,
    parameter int NREG    = 16,
    parameter int IDXW    = 5,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [NREG-1:0]  wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [NREG-1:0]  rd_sel,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic [IDXW-1:0]  sel_index,
    output logic             sel_err,
    input  logic             dump_req,
    output logic             dump_busy,
    output logic             dump_valid,
    output logic [IDXW-1:0]  dump_idx,
    output logic [WIDTH-1:0] dump_data
);

    localparam logic [IDXW-1:0] IDX_NONE = '1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREG - 1);

    typedef enum logic {
        S_IDLE,
        S_DUMP
    } dump_state_t;

    logic [WIDTH-1:0] regs [NREG];

    logic             wr_one;
    logic             wr_multi;
    logic             rd_one;
    logic             rd_multi;
    logic [IDXW-1:0]  rd_idx;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] rd_next;

    dump_state_t      state;
    dump_state_t      state_nxt;
    logic [IDXW-1:0]  idx_nxt;

    function automatic logic is_onehot(input logic [NREG-1:0] s);
        return (s != '0) && ((s & (s - NREG'(1))) == '0);
    endfunction

    function automatic logic [IDXW-1:0] encode(input logic [NREG-1:0] s);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREG; i++) begin
            if (s[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

    always_comb begin
        wr_one   = is_onehot(wr_sel);
        wr_multi = (wr_sel != '0) && !wr_one;
        rd_one   = is_onehot(rd_sel);
        rd_multi = (rd_sel != '0) && !rd_one;
        rd_idx   = encode(rd_sel);
    end

    // AND-OR mux is exact because it is only consumed for one-hot selects.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_sel[i]) rd_word = rd_word | regs[i];
        end
    end

    always_comb begin
        rd_next = rd_word;
        if (wr_one && (wr_sel == rd_sel)) rd_next = wr_data;
        if ((ZERO_R0 != 0) && rd_sel[0]) rd_next = '0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_one && wr_sel[i] && !((ZERO_R0 != 0) && (i == 0)))
                    regs[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
            sel_index <= IDX_NONE;
        end else if (rd_en) begin
            if (rd_one) begin
                bus_out   <= rd_next;
                bus_valid <= 1'b1;
                sel_index <= rd_idx;
            end else begin
                bus_out   <= '0;
                bus_valid <= 1'b0;
                sel_index <= IDX_NONE;
            end
        end else begin
            bus_valid <= 1'b0;
        end
    end

    // A new violation takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel_err <= 1'b0;
        end else if (wr_multi || (rd_en && rd_multi)) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            dump_idx <= '0;
        end else begin
            state    <= state_nxt;
            dump_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = dump_idx;
        unique case (state)
            S_IDLE: begin
                idx_nxt = '0;
                if (dump_req) state_nxt = S_DUMP;
            end
            S_DUMP: begin
                if (dump_idx == IDX_LAST) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = dump_idx + IDXW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Reads the pre-write contents, so a same-cycle write is not visible.
    always_comb begin
        dump_busy  = (state == S_DUMP);
        dump_valid = (state == S_DUMP);
        dump_data  = '0;
        if (state == S_DUMP) begin
            for (int i = 0; i < NREG; i++) begin
                if (dump_idx == IDXW'(i)) dump_data = regs[i];
            end
        end
    end

endmodule

// File: doc/bus_register_bank.md
Name: bus_register_bank

Overview:
- Parametrised general-purpose register bank with a single shared-bus read port and a single write port. Generalises the fixed 32-bit, 16-register datapath bank.
- Selects are one-hot, as driven by the control unit. The bank performs the one-hot-to-index encoding internally and reports it.
- Adds three capabilities the fixed bank lacks:
  - a registered bus output with a valid flag;
  - sticky detection of illegal (multi-hot) selects;
  - optional hardwired-zero R0.
- Includes a sequential register-dump engine for debug and testbench readout.

Parameters:
- WIDTH, 32, data width of every register and of the bus.
- NREG, 16, number of registers (2..32).
- IDXW, 5, index width. Must satisfy 2**IDXW >= NREG + 1, so that the all-ones index is never a legal register index.
- ZERO_R0, 0, if 1 then R0 always reads 0 and writes to R0 are discarded.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- wr_sel  in  NREG  one-hot write select. Bit i selects Ri.
- wr_data  in  WIDTH  write data, taken from BusMuxOut.
- rd_en  in  1  bus read request.
- rd_sel  in  NREG  one-hot read select.
- err_clr  in  1  synchronous clear of sel_err.
- bus_out  out  WIDTH  registered bus data.
- bus_valid  out  1  bus_out holds a legal read result this cycle.
- sel_index  out  IDXW  encoded index of the last accepted read. All-ones means none or invalid.
- sel_err  out  1  sticky flag: a multi-hot wr_sel or rd_sel was seen.
- dump_req  in  1  start a dump of all registers.
- dump_busy  out  1  dump in progress.
- dump_valid  out  1  dump_data/dump_idx are valid this cycle.
- dump_idx  out  IDXW  index of the register currently being dumped.
- dump_data  out  WIDTH  contents of register dump_idx.

Behaviour:
- Reset (clr=1, asynchronous, held for any duration):
  - all registers = 0;
  - bus_out = 0, bus_valid = 0, sel_index = all-ones, sel_err = 0;
  - dump FSM forced to IDLE; dump_busy = dump_valid = 0, dump_idx = 0, dump_data = 0.
  - A reset arriving mid-dump aborts the dump immediately.
- Write, sampled on the rising edge:
  - wr_sel with exactly one bit i set: Ri <= wr_data. If ZERO_R0=1 and i=0, the write is discarded.
  - wr_sel = 0: no write.
  - wr_sel multi-hot: no register is written, and sel_err <= 1.
- Read, 1-cycle latency:
  - rd_en=1 with rd_sel one-hot at bit i: next cycle bus_out = Ri, bus_valid = 1, sel_index = i.
  - Same-cycle write to the same Ri: bus_out returns wr_data (write-through bypass). With ZERO_R0=1, R0 still returns 0.
  - rd_en=1 with rd_sel = 0: next cycle bus_out = 0, bus_valid = 0, sel_index = all-ones.
  - rd_en=1 with rd_sel multi-hot: same response as rd_sel = 0, plus sel_err <= 1.
  - rd_en=0: bus_out and sel_index hold their previous values; bus_valid = 0.
- sel_err:
  - Set by any multi-hot select.
  - Cleared only by clr or by err_clr.
  - err_clr and a new violation in the same cycle: set wins.
- Dump FSM, states IDLE and DUMP:
  - IDLE: dump_req=1 moves to DUMP with dump_idx = 0.
  - DUMP: each cycle drives dump_valid = 1, dump_idx = k, dump_data = Rk, where Rk is the value before any write in that cycle. dump_idx then increments.
  - After k = NREG-1 has been presented, the FSM returns to IDLE. dump_valid and dump_busy fall the cycle after the last entry.
  - dump_busy = 1 throughout DUMP. A full dump takes exactly NREG cycles.
  - dump_req while in DUMP is ignored, and no restart is queued.
  - dump_req held high continuously starts a new dump after a single IDLE cycle.
  - The bus read and write ports operate normally during a dump.
- Arithmetic and width:
  - dump_idx counts modulo NREG, never NREG itself.
  - No WIDTH truncation occurs anywhere; all data paths are exactly WIDTH bits.

Test Plan:
1. Write 32'hDEADBEEF with wr_sel=1<<5; next cycle rd_en=1, rd_sel=1<<5 -> one cycle later bus_out=32'hDEADBEEF, bus_valid=1, sel_index=5.
2. Same cycle: write 32'h12345678 to R3 and read R3 -> bus_out=32'h12345678 next cycle. With ZERO_R0=1, write 32'hFFFFFFFF to R0 then read R0 -> bus_out=0, bus_valid=1, sel_index=0.
3. wr_sel=16'h0011 with data 32'hAAAA5555 -> R0 and R4 unchanged, sel_err=1. sel_err stays 1 across 10 idle cycles. err_clr=1 for one cycle -> sel_err=0.
4. rd_en=1, rd_sel=0 -> bus_valid=0, sel_index=5'b11111, sel_err stays 0.
5. Load Ri=i+100 for all i; pulse dump_req -> 16 consecutive cycles of dump_valid=1 with dump_idx 0..15 and dump_data 100..115. dump_busy=1 for exactly 16 cycles. A second dump_req at cycle 8 has no effect.
6. Assert clr asynchronously (between clock edges) at cycle 6 of a dump -> dump_busy=0, dump_valid=0, bus_out=0, all registers 0, with no clock edge needed. After release, a read of R7 returns 0.
